dev_debug_output: RTL and testbench
===================================

// Module: dev_debug_output
// PURPOSE
//   Debug output device: the write-side counterpart of the debug input device.
//   CPU stores to the device window are queued in a FIFO.
//   A testbench/host port drains the FIFO with a valid/ready handshake.
//   Sits on the device bus alongside the other dev_* blocks (same dev_out/dev_in/dev_addr/we contract).
// PARAMETERS
//   DEPTH  16  FIFO entries; power of two, >= 2
//   AW     4   log2(DEPTH); pointer width
// PORTS
//   clk        in   1      single clock; all state updates on posedge clk
//   rst        in   1      asynchronous, active-high reset
//   dev_out    out  32     read data to CPU (combinational from dev_addr/state)
//   dev_in     in   32     write data from CPU
//   dev_addr   in   8      byte offset within device window
//   we         in   1      write enable; write happens at posedge clk
//   out_data   out  32     FIFO head word to host
//   out_valid  out  1      FIFO non-empty
//   out_ready  in   1      host accepts head word this cycle
// BEHAVIOUR
//   Reset (async, rst=1): wr_ptr=rd_ptr=0, count=0, overflow=0, total=0 -> out_valid=0.
//     FIFO storage is not reset; out_data is don't-care while out_valid=0.
//   Register map (dev_addr):
//     0x00 W: push dev_in. R: head word if non-empty, else 0.
//     0x04 W: any value clears overflow. R: {13'b0, overflow[18], full[17], empty[16], count[15:0]}; count zero-extended.
//     0x08 R: total accepted pushes, 32-bit, wraps 0xFFFFFFFF->0. W: ignored.
//     other R: 32'hDEAD_BEEF; other W: ignored, no state change.
//   Push: we && dev_addr==0x00.
//     Accepted if !full, or if a pop occurs in the same cycle.
//     If full with no pop, the word is dropped and overflow is set (sticky).
//     Accepted push increments total.
//   Pop: out_valid && out_ready at posedge; advances rd_ptr.
//   Latency: a word pushed at edge N gives out_valid=1 and out_data=word after edge N.
//     No same-cycle bypass from dev_in to out_data.
//   Simultaneous push+pop:
//     count unchanged; both pointers advance.
//     At empty, the pop cannot occur (out_valid=0), so the push alone lands.
//   Overflow clear (write 0x04) and an overflowing push in the same cycle: overflow ends at 1 (set wins).
//   Pointers wrap modulo DEPTH.
//   count in 0..DEPTH; full = count==DEPTH; empty = count==0.
//   Reset mid-drain: contents are discarded; out_valid drops asynchronously with rst.
//   dev_out and out_data are pure combinational functions of registered state and dev_addr; no read side effects.
// STRUCTURE
//   Shared package/header dev_debug_pkg:
//     DEV_DBG_ADDR_DATA=8'h00, DEV_DBG_ADDR_STAT=8'h04, DEV_DBG_ADDR_TOTAL=8'h08
//     DEV_DBG_BADREAD=32'hDEAD_BEEF (also used by dev_debug_input)
//     status bit positions STAT_EMPTY=16, STAT_FULL=17, STAT_OVF=18
//   Sub-module sync_fifo #(W=32,DEPTH,AW):
//     ports push, din, pop, dout, count, full, empty, with async reset.
//   Top-level module: address decode, overflow/total registers, read mux.
// TESTING
//   1 Reset, then read 0x04 -> 0x0001_0000 (empty, count 0).
//     Read 0x08 -> 0; read 0x10 -> 0xDEADBEEF; out_valid=0.
//   2 Write 0x11,0x22,0x33 to 0x00 with out_ready=0.
//     Status count=3, out_data=0x11.
//     Then out_ready=1 for 3 cycles -> host sees 0x11,0x22,0x33 in order; then out_valid=0, total=3.
//   3 Write 17 words (DEPTH=16) with out_ready=0.
//     Status -> full=1, overflow=1, count=16 (0x0006_0010), total=16.
//     Word 17 is lost; write 0x04 -> overflow=0.
//   4 Fill to full, then hold out_ready=1 and push every cycle for 40 cycles.
//     No overflow; count stays 16; host receives every word in order; total=56.
//   5 Push 0xA5A5A5A5 while empty with out_ready=1.
//     out_valid rises the next cycle and the word pops exactly once.
//   6 Assert rst asynchronously mid-drain with count=5.
//     out_valid=0 immediately; status 0x0001_0000 after release; next push is returned as the head.

Source files
------------

// File: rtl/dev_debug_pkg.sv
// dev_debug_pkg: shared register map and status layout for the dev_debug blocks
package dev_debug_pkg;
    localparam logic [7:0]  DEV_DBG_ADDR_DATA  = 8'h00;
    localparam logic [7:0]  DEV_DBG_ADDR_STAT  = 8'h04;
    localparam logic [7:0]  DEV_DBG_ADDR_TOTAL = 8'h08;
    localparam logic [31:0] DEV_DBG_BADREAD    = 32'hDEAD_BEEF;
    localparam int STAT_EMPTY = 16;
    localparam int STAT_FULL  = 17;
    localparam int STAT_OVF   = 18;

    function automatic logic [31:0] stat_word(input logic ovf, input logic full, input logic empty,
                                              input logic [15:0] count);
        logic [31:0] w;
        w = {16'h0, count};
        w[STAT_EMPTY] = empty;
        w[STAT_FULL]  = full;
        w[STAT_OVF]   = ovf;
        return w;
    endfunction
endpackage

// File: rtl/dev_debug_output_if.sv
// dev_debug_output_if: CPU device-bus and host drain-port signals of the debug output device
interface dev_debug_output_if;
    logic [31:0] dev_out;
    logic [31:0] dev_in;
    logic [7:0]  dev_addr;
    logic        we;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    modport master (input dev_out, out_data, out_valid, output dev_in, dev_addr, we, out_ready);
    modport slave  (output dev_out, out_data, out_valid, input dev_in, dev_addr, we, out_ready);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; caller only asserts push/pop when they are legal
module sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // storage is deliberately left unreset; dout is ignored while empty
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = r_count == (AW+1)'(DEPTH);
    assign empty = r_count == '0;
endmodule

// File: rtl/dev_debug_output.sv
// dev_debug_output: CPU stores queued in a FIFO and drained by a host valid/ready port
module dev_debug_output
    import dev_debug_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic               clk,
    input  logic               rst,
    dev_debug_output_if.slave  bus
);
    logic          w_push_req;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_clr;
    logic [AW:0]   w_count;
    logic [31:0]   w_head;
    logic          r_ovf;
    logic [31:0]   r_total;

    assign w_pop      = !w_empty && bus.out_ready;
    assign w_push_req = bus.we && bus.dev_addr == DEV_DBG_ADDR_DATA;
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_clr      = bus.we && bus.dev_addr == DEV_DBG_ADDR_STAT;

    sync_fifo #(.W(32), .DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (bus.dev_in),
        .pop   (w_pop),
        .dout  (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    // a dropped push sets overflow even when a clear lands in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf   <= 1'b0;
            r_total <= '0;
        end else begin
            r_ovf   <= (w_push_req && !w_push) || (r_ovf && !w_clr);
            r_total <= r_total + 32'(w_push);
        end
    end

    assign bus.out_valid = !w_empty;
    assign bus.out_data  = w_head;

    always_comb begin
        bus.dev_out = bus.dev_addr == DEV_DBG_ADDR_DATA  ? (w_empty ? 32'h0 : w_head) :
                      bus.dev_addr == DEV_DBG_ADDR_STAT  ? stat_word(r_ovf, w_full, w_empty, 16'(w_count)) :
                      bus.dev_addr == DEV_DBG_ADDR_TOTAL ? r_total : DEV_DBG_BADREAD;
    end
endmodule

// File: tb/tb_dev_debug_output.sv
// tb_dev_debug_output: directed self-checking bench for dev_debug_output
module tb_dev_debug_output;
    logic clk;
    logic rst;
    int checks;
    int errors;
    logic [31:0] q[$];
    logic [31:0] exp_w;

    dev_debug_output_if dbg ();

    dev_debug_output #(.DEPTH(16), .AW(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
        dbg.dev_addr = a;
        #1;
        chk(tag, dbg.dev_out, exp);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        dbg.dev_addr = a;
        dbg.dev_in   = d;
        dbg.we       = 1'b1;
        @(posedge clk);
        #1;
        dbg.we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        dbg.dev_in = '0;
        dbg.dev_addr = '0;
        dbg.we = 1'b0;
        dbg.out_ready = 1'b0;
        do_reset();

        // reset state
        chk("rst_valid", 32'(dbg.out_valid), 32'h0);
        rd("rst_stat", 8'h04, 32'h0001_0000);
        rd("rst_total", 8'h08, 32'h0);
        rd("rst_bad", 8'h10, 32'hDEAD_BEEF);
        rd("rst_data", 8'h00, 32'h0);

        // three words, then drain in order
        wr(8'h00, 32'h11);
        wr(8'h00, 32'h22);
        wr(8'h00, 32'h33);
        rd("t2_stat", 8'h04, 32'h0000_0003);
        rd("t2_rdhead", 8'h00, 32'h11);
        chk("t2_head", dbg.out_data, 32'h11);
        rd("t2_bad_c", 8'h0C, 32'hDEAD_BEEF);
        dbg.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_w = 32'h11 * 32'(i + 1);
            chk("t2_valid", 32'(dbg.out_valid), 32'h1);
            chk("t2_drain", dbg.out_data, exp_w);
            @(posedge clk);
            #1;
        end
        dbg.out_ready = 1'b0;
        chk("t2_empty", 32'(dbg.out_valid), 32'h0);
        rd("t2_total", 8'h08, 32'd3);

        // overflow: 17 pushes into 16 entries
        do_reset();
        for (int i = 0; i < 17; i++) wr(8'h00, 32'h100 + 32'(i));
        for (int i = 0; i < 16; i++) q.push_back(32'h100 + 32'(i));
        rd("t3_stat", 8'h04, 32'h0006_0010);
        rd("t3_total", 8'h08, 32'd16);
        wr(8'h08, 32'h1234);
        rd("t3_total_ro", 8'h08, 32'd16);
        wr(8'h04, 32'h0);
        rd("t3_clr", 8'h04, 32'h0002_0010);

        // full FIFO with simultaneous push and pop every cycle
        dbg.out_ready = 1'b1;
        dbg.dev_addr = 8'h00;
        for (int i = 0; i < 40; i++) begin
            dbg.dev_in = 32'h200 + 32'(i);
            dbg.we = 1'b1;
            chk("t4_stream", dbg.out_data, q.pop_front());
            q.push_back(32'h200 + 32'(i));
            @(posedge clk);
            #1;
        end
        dbg.we = 1'b0;
        dbg.out_ready = 1'b0;
        rd("t4_stat", 8'h04, 32'h0002_0010);
        rd("t4_total", 8'h08, 32'd56);
        dbg.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t4_valid", 32'(dbg.out_valid), 32'h1);
            chk("t4_drain", dbg.out_data, q.pop_front());
            @(posedge clk);
            #1;
        end
        chk("t4_empty", 32'(dbg.out_valid), 32'h0);

        // push into empty FIFO with host ready
        dbg.dev_addr = 8'h00;
        dbg.dev_in = 32'hA5A5_A5A5;
        dbg.we = 1'b1;
        #1;
        chk("t5_nobypass", 32'(dbg.out_valid), 32'h0);
        @(posedge clk);
        #1;
        dbg.we = 1'b0;
        chk("t5_valid", 32'(dbg.out_valid), 32'h1);
        chk("t5_data", dbg.out_data, 32'hA5A5_A5A5);
        @(posedge clk);
        #1;
        chk("t5_once", 32'(dbg.out_valid), 32'h0);
        dbg.out_ready = 1'b0;
        rd("t5_total", 8'h08, 32'd57);

        // async reset mid-drain
        for (int i = 0; i < 6; i++) wr(8'h00, 32'h300 + 32'(i));
        dbg.out_ready = 1'b1;
        @(posedge clk);
        #1;
        dbg.out_ready = 1'b0;
        rd("t6_stat", 8'h04, 32'h0000_0005);
        rd("t6_head", 8'h00, 32'h301);
        @(posedge clk);
        #1;
        dbg.out_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async", 32'(dbg.out_valid), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        dbg.out_ready = 1'b0;
        rd("t6_stat_rst", 8'h04, 32'h0001_0000);
        rd("t6_total_rst", 8'h08, 32'h0);
        wr(8'h00, 32'hCAFE_0001);
        chk("t6_valid", 32'(dbg.out_valid), 32'h1);
        chk("t6_newhead", dbg.out_data, 32'hCAFE_0001);
        rd("t6_stat_new", 8'h04, 32'h0000_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
